inst_buffer: RTL and testbench

- Circular FIFO between fetch and dispatch, directly upstream of the ROB and RS.
- Decouples fetch from dispatch stalls and holds fetched DP_PACKETs in program order.
- Presents the oldest packet to dispatch, which consumes it when both ROB and RS accept.
- Flushes completely on a branch-mispredict squash.

---
 rtl/inst_buffer_pkg.sv | 18 +
 rtl/inst_buffer_if.sv | 35 +++
 rtl/inst_buffer_ib_ptr_ctr.sv | 35 +++
 rtl/inst_buffer.sv | 122 ++++++++++++
 tb/tb_inst_buffer.sv | 389 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/inst_buffer_pkg.sv
// Shared types and defaults for the fetch-to-dispatch instruction buffer.
package inst_buffer_pkg;

  localparam int unsigned IB_DEPTH_DEF = 8;
  localparam int unsigned IB_PTR_W_DEF = $clog2(IB_DEPTH_DEF);

  typedef logic [IB_PTR_W_DEF-1:0] IB_PTR;

  // Decoded packet handed from fetch/decode to dispatch; contents are opaque to the buffer.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] npc;
    logic [31:0] inst;
    logic [4:0]  dest_reg;
    logic        valid;
  } DP_PACKET;

endpackage

// File: rtl/inst_buffer_if.sv
// Fetch/dispatch signal bundle of the instruction buffer.
// master: the surrounding pipeline (fetch, ROB/RS availability, squash).
// slave: the buffer itself.
interface inst_buffer_if
  import inst_buffer_pkg::*;
#(
  parameter int unsigned IB_DEPTH = IB_DEPTH_DEF
);

  localparam int unsigned IB_PTR_W = $clog2(IB_DEPTH);

  logic              if_valid;
  DP_PACKET          if_packet;
  logic              ib_if_ready;
  logic              rob_dp_available;
  logic              rs_dp_available;
  logic              squash;
  logic              dp_valid;
  DP_PACKET          dp_packet;
  logic              dp_fire;
  logic [IB_PTR_W:0] ib_count;
  logic              ib_empty;
  logic              ib_full;

  modport master (
    output if_valid, if_packet, rob_dp_available, rs_dp_available, squash,
    input  ib_if_ready, dp_valid, dp_packet, dp_fire, ib_count, ib_empty, ib_full
  );

  modport slave (
    input  if_valid, if_packet, rob_dp_available, rs_dp_available, squash,
    output ib_if_ready, dp_valid, dp_packet, dp_fire, ib_count, ib_empty, ib_full
  );

endinterface

// File: rtl/inst_buffer_ib_ptr_ctr.sv
// Wrapping ring pointer for the instruction buffer; used for both head and tail.
module inst_buffer_ib_ptr_ctr #(
  parameter int unsigned PTR_W = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  output logic [PTR_W-1:0] ptr
);

  logic [PTR_W-1:0] ptr_q, ptr_d;

  // Next pointer: clear wins, otherwise wrap naturally modulo 2**PTR_W.
  always_comb begin
    ptr_d = ptr_q;
    if (clear) begin
      ptr_d = '0;
    end else if (inc) begin
      ptr_d = ptr_q + PTR_W'(1);
    end
  end

  // Pointer register, asynchronously cleared.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/inst_buffer.sv
// Instruction buffer: circular FIFO between fetch and dispatch, holding packets in program
// order and flushing entirely on a mispredict squash.
// Optional build macro IB_BYPASS_EN: an empty buffer forwards if_packet straight to dispatch
// in the same cycle when dispatch can accept it.
module inst_buffer
  import inst_buffer_pkg::*;
#(
  parameter int unsigned IB_DEPTH = IB_DEPTH_DEF,
  parameter int unsigned IB_PTR_W = $clog2(IB_DEPTH)
) (
  input logic         clock,
  input logic         reset,
  inst_buffer_if.slave ib
);

  localparam int unsigned      CntW    = IB_PTR_W + 1;
  localparam logic [IB_PTR_W:0] FullCnt = IB_DEPTH[IB_PTR_W:0];

  DP_PACKET            mem_q [IB_DEPTH];
  logic [IB_PTR_W:0]   count_q, count_d;
  logic [IB_PTR_W-1:0] head_ptr, tail_ptr;

  logic     full, empty, both_avail, bypass;
  logic     enq, deq, fire;
  logic     dp_valid;
  DP_PACKET dp_packet;

  assign full       = (count_q == FullCnt);
  assign empty      = (count_q == '0);
  assign both_avail = ib.rob_dp_available & ib.rs_dp_available;

`ifdef IB_BYPASS_EN
  // Empty buffer with a dispatch slot ready: hand the fetched packet straight through.
  assign bypass = empty & ib.if_valid & both_avail & ~ib.squash;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed packet is consumed on the spot, so it is neither written nor dequeued.
  assign enq  = ib.if_valid & ~full & ~ib.squash & ~bypass;
  assign fire = dp_valid & both_avail & ~ib.squash;
  assign deq  = fire & ~bypass;

  inst_buffer_ib_ptr_ctr #(
    .PTR_W (IB_PTR_W)
  ) u_head_ctr (
    .clock (clock),
    .reset (reset),
    .clear (ib.squash),
    .inc   (deq),
    .ptr   (head_ptr)
  );

  inst_buffer_ib_ptr_ctr #(
    .PTR_W (IB_PTR_W)
  ) u_tail_ctr (
    .clock (clock),
    .reset (reset),
    .clear (ib.squash),
    .inc   (enq),
    .ptr   (tail_ptr)
  );

  // Occupancy: squash empties; enq and deq together leave it unchanged.
  always_comb begin
    count_d = count_q;
    if (ib.squash) begin
      count_d = '0;
    end else begin
      count_d = count_q + CntW'(enq) - CntW'(deq);
    end
  end

  // Occupancy register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Entry storage; dequeued and squashed entries are zeroed so stale packets never linger.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_q <= '{default: '0};
    end else if (ib.squash) begin
      mem_q <= '{default: '0};
    end else begin
      // enq and deq never target the same slot: both together imply 0 < count < depth.
      if (enq) begin
        mem_q[tail_ptr] <= ib.if_packet;
      end
      if (deq) begin
        mem_q[head_ptr] <= '0;
      end
    end
  end

  // Dispatch view: oldest entry, the bypassed fetch packet, or all-zero when nothing is live.
  always_comb begin
    dp_valid  = 1'b0;
    dp_packet = '0;
    if (bypass) begin
      dp_valid  = 1'b1;
      dp_packet = ib.if_packet;
    end else if (!empty) begin
      dp_valid  = 1'b1;
      dp_packet = mem_q[head_ptr];
    end
  end

  assign ib.dp_valid    = dp_valid;
  assign ib.dp_packet   = dp_packet;
  assign ib.dp_fire     = fire;
  assign ib.ib_count    = count_q;
  assign ib.ib_empty    = empty;
  assign ib.ib_full     = full;
  // Depends on occupancy only, keeping fetch readiness free of dispatch-side paths.
  assign ib.ib_if_ready = ~full;

endmodule

// File: tb/tb_inst_buffer.sv
module tb_inst_buffer;
  import inst_buffer_pkg::*;

`ifdef IB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  inst_buffer_if #(.IB_DEPTH(8)) bus ();

  inst_buffer #(
    .IB_DEPTH (8)
  ) dut (
    .clock (clock),
    .reset (reset),
    .ib    (bus)
  );

  // Scoreboard: packets expected at dispatch, oldest first, plus model pointers.
  DP_PACKET exp_q[$];
  int       m_head = 0;
  int       m_tail = 0;
  int       vec = 0;
  int       miss = 0;
  logic     last_acc;

  logic     cur_v, cur_rob, cur_rs, cur_sq;
  DP_PACKET cur_pkt;
  logic [8:0] exp_st;
  DP_PACKET   exp_pkt;

  // {dp_valid, dp_fire, ib_count[3:0], ib_empty, ib_full, ib_if_ready}
  logic [8:0] obs_st;
  assign obs_st = {bus.dp_valid, bus.dp_fire, bus.ib_count, bus.ib_empty, bus.ib_full,
                   bus.ib_if_ready};

  localparam logic [8:0] RstSt = 9'b0_0_0000_1_0_1;

  function automatic DP_PACKET mk(input logic [31:0] pc);
    DP_PACKET p;
    p.pc       = pc;
    p.npc      = pc + 32'd4;
    p.inst     = 32'h0000_0013 ^ {pc[15:0], 16'h0};
    p.dest_reg = pc[6:2];
    p.valid    = 1'b1;
    return p;
  endfunction

  // Expected dispatch-side view for the current inputs and model contents.
  function automatic void predict();
    int   n;
    logic byp, v, f;
    n   = exp_q.size();
    byp = BYP && (n == 0) && cur_v && cur_rob && cur_rs && !cur_sq;
    v   = (n != 0) || byp;
    f   = v && cur_rob && cur_rs && !cur_sq;
    exp_pkt = '0;
    if (byp) exp_pkt = cur_pkt;
    else if (n != 0) exp_pkt = exp_q[0];
    exp_st = {v, f, 4'(n), n == 0, n == 8, n != 8};
  endfunction

  // Apply inputs just after an edge, settle to the falling edge, compute expectations.
  task automatic drive(input logic v, input logic [31:0] pc, input logic rob, input logic rs,
                       input logic sq);
    cur_v = v; cur_pkt = mk(pc); cur_rob = rob; cur_rs = rs; cur_sq = sq;
    bus.if_valid = v;
    bus.if_packet = cur_pkt;
    bus.rob_dp_available = rob;
    bus.rs_dp_available = rs;
    bus.squash = sq;
    @(negedge clock);
    predict();
  endtask

  // Clock edge plus model update.
  task automatic advance();
    int       n;
    logic     byp, fire, enq;
    DP_PACKET dummy;
    n    = exp_q.size();
    byp  = BYP && (n == 0) && cur_v && cur_rob && cur_rs && !cur_sq;
    fire = (n != 0) && cur_rob && cur_rs && !cur_sq;
    enq  = cur_v && (n < 8) && !cur_sq && !byp;
    last_acc = enq || byp;
    @(posedge clock);
    #1;
    if (cur_sq) begin
      exp_q.delete();
      m_head = 0;
      m_tail = 0;
    end else begin
      if (fire) begin
        dummy  = exp_q.pop_front();
        m_head = (m_head + 1) % 8;
      end
      if (enq) begin
        exp_q.push_back(cur_pkt);
        m_tail = (m_tail + 1) % 8;
      end
    end
  endtask

  task automatic test_reset();
    cur_v = 0; cur_rob = 0; cur_rs = 0; cur_sq = 0; cur_pkt = mk(0);
    bus.if_valid = 0; bus.if_packet = cur_pkt; bus.rob_dp_available = 0;
    bus.rs_dp_available = 0; bus.squash = 0;
    #3;
    vec++;
    if (obs_st !== RstSt || bus.dp_packet !== '0) begin
      miss++;
      $display("FAIL reset_held st=%b pc=%h want st=%b pc=0", obs_st, bus.dp_packet.pc, RstSt);
    end
    #4 reset = 1'b0;
    @(posedge clock);
    #1;
    drive(0, 0, 1, 1, 0);
    vec++;
    if (obs_st !== RstSt || bus.dp_packet !== '0) begin
      miss++;
      $display("FAIL reset_idle st=%b pc=%h want st=%b pc=0", obs_st, bus.dp_packet.pc, RstSt);
    end
    advance();
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'(4 * i), 0, 0, 0);
      vec++;
      if (obs_st !== exp_st || bus.dp_packet !== exp_pkt) begin
        miss++;
        $display("FAIL fill[%0d] st=%b pc=%h want st=%b pc=%h", i, obs_st, bus.dp_packet.pc,
                 exp_st, exp_pkt.pc);
      end
      advance();
    end
    drive(0, 0, 0, 0, 0);
    vec++;
    if (bus.ib_count !== 4'd3 || bus.dp_packet.pc !== 32'h0 || bus.dp_fire !== 1'b0) begin
      miss++;
      $display("FAIL filled cnt=%0d pc=%h fire=%b want cnt=3 pc=0 fire=0", bus.ib_count,
               bus.dp_packet.pc, bus.dp_fire);
    end
    advance();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 1, 0);
      vec++;
      if (bus.dp_fire !== 1'b1 || bus.dp_packet !== exp_pkt || obs_st !== exp_st) begin
        miss++;
        $display("FAIL drain[%0d] fire=%b pc=%h st=%b want fire=1 pc=%h st=%b", i, bus.dp_fire,
                 bus.dp_packet.pc, obs_st, exp_pkt.pc, exp_st);
      end
      advance();
    end
    drive(0, 0, 0, 0, 0);
    vec++;
    if (bus.ib_empty !== 1'b1 || bus.dp_valid !== 1'b0) begin
      miss++;
      $display("FAIL drained empty=%b valid=%b want empty=1 valid=0", bus.ib_empty, bus.dp_valid);
    end
    advance();
  endtask

  task automatic test_full();
    for (int i = 0; i < 8; i++) begin
      drive(1, 32'h100 + 32'(4 * i), 0, 0, 0);
      vec++;
      if (obs_st !== exp_st || bus.dp_packet !== exp_pkt) begin
        miss++;
        $display("FAIL full_fill[%0d] st=%b pc=%h want st=%b pc=%h", i, obs_st,
                 bus.dp_packet.pc, exp_st, exp_pkt.pc);
      end
      advance();
    end
    // Ninth packet offered while full, ROB stalled but RS free.
    drive(1, 32'h200, 0, 1, 0);
    vec++;
    if (bus.ib_full !== 1'b1 || bus.ib_if_ready !== 1'b0 || bus.ib_count !== 4'd8 ||
        bus.dp_fire !== 1'b0) begin
      miss++;
      $display("FAIL full full=%b ready=%b cnt=%0d fire=%b want 1 0 8 0", bus.ib_full,
               bus.ib_if_ready, bus.ib_count, bus.dp_fire);
    end
    advance();
    drive(0, 0, 0, 0, 0);
    vec++;
    if (bus.ib_count !== 4'd8) begin
      miss++;
      $display("FAIL full_ignore cnt=%0d want 8", bus.ib_count);
    end
    advance();
    drive(0, 0, 1, 1, 0);
    vec++;
    if (obs_st !== exp_st || bus.dp_packet !== exp_pkt) begin
      miss++;
      $display("FAIL full_deq st=%b pc=%h want st=%b pc=%h", obs_st, bus.dp_packet.pc, exp_st,
               exp_pkt.pc);
    end
    advance();
    drive(0, 0, 0, 0, 0);
    vec++;
    if (bus.ib_count !== 4'd7 || bus.ib_if_ready !== 1'b1) begin
      miss++;
      $display("FAIL full_release cnt=%0d ready=%b want 7 1", bus.ib_count, bus.ib_if_ready);
    end
    advance();
    for (int i = 0; i < 12 && exp_q.size() != 0; i++) begin
      drive(0, 0, 1, 1, 0);
      vec++;
      if (obs_st !== exp_st || bus.dp_packet !== exp_pkt) begin
        miss++;
        $display("FAIL full_drain[%0d] st=%b pc=%h want st=%b pc=%h", i, obs_st,
                 bus.dp_packet.pc, exp_st, exp_pkt.pc);
      end
      advance();
    end
    drive(0, 0, 0, 0, 0);
    vec++;
    if (bus.ib_empty !== 1'b1) begin
      miss++;
      $display("FAIL full_drained empty=%b want 1", bus.ib_empty);
    end
    advance();
  endtask

  task automatic test_simul_wrap();
    int sent;
    for (int i = 0; i < 5; i++) begin
      drive(1, 32'h300 + 32'(4 * i), 0, 0, 0);
      advance();
    end
    drive(1, 32'h314, 1, 1, 0);
    vec++;
    if (obs_st !== exp_st || bus.dp_packet !== exp_pkt) begin
      miss++;
      $display("FAIL simul st=%b pc=%h want st=%b pc=%h", obs_st, bus.dp_packet.pc, exp_st,
               exp_pkt.pc);
    end
    advance();
    drive(0, 0, 0, 0, 0);
    vec++;
    if (bus.ib_count !== 4'd5 || dut.head_ptr !== IB_PTR'(m_head) ||
        dut.tail_ptr !== IB_PTR'(m_tail) || bus.dp_packet !== exp_pkt) begin
      miss++;
      $display("FAIL simul_after cnt=%0d head=%0d tail=%0d pc=%h want 5 %0d %0d pc=%h",
               bus.ib_count, dut.head_ptr, dut.tail_ptr, bus.dp_packet.pc, m_head, m_tail,
               exp_pkt.pc);
    end
    advance();
    // Twenty packets through with a bursty ROB, crossing the pointer wrap several times.
    sent = 0;
    for (int c = 0; c < 200 && (sent < 20 || exp_q.size() != 0); c++) begin
      drive(sent < 20, 32'h1000 + 32'(4 * sent), $urandom_range(0, 3) != 0, 1, 0);
      vec++;
      if (obs_st !== exp_st || bus.dp_packet !== exp_pkt || dut.head_ptr !== IB_PTR'(m_head) ||
          dut.tail_ptr !== IB_PTR'(m_tail)) begin
        miss++;
        $display("FAIL wrap[%0d] st=%b pc=%h h=%0d t=%0d want st=%b pc=%h h=%0d t=%0d", c,
                 obs_st, bus.dp_packet.pc, dut.head_ptr, dut.tail_ptr, exp_st, exp_pkt.pc,
                 m_head, m_tail);
      end
      advance();
      if (last_acc) sent++;
    end
    vec++;
    if (sent != 20 || bus.ib_empty !== 1'b1) begin
      miss++;
      $display("FAIL wrap_end sent=%0d empty=%b want sent=20 empty=1", sent, bus.ib_empty);
    end
  endtask

  task automatic test_squash();
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'h500 + 32'(4 * i), 0, 0, 0);
      advance();
    end
    drive(1, 32'hDEAD0, 1, 1, 1);
    vec++;
    if (bus.dp_fire !== 1'b0 || obs_st !== exp_st || bus.dp_packet !== exp_pkt) begin
      miss++;
      $display("FAIL squash_cyc fire=%b st=%b want fire=0 st=%b", bus.dp_fire, obs_st, exp_st);
    end
    advance();
    drive(0, 0, 1, 1, 0);
    vec++;
    if (bus.ib_count !== 4'd0 || bus.dp_valid !== 1'b0 || bus.dp_packet !== '0 ||
        dut.head_ptr !== IB_PTR'(0) || dut.tail_ptr !== IB_PTR'(0)) begin
      miss++;
      $display("FAIL squash_after cnt=%0d valid=%b pc=%h h=%0d t=%0d want 0 0 0 0 0",
               bus.ib_count, bus.dp_valid, bus.dp_packet.pc, dut.head_ptr, dut.tail_ptr);
    end
    advance();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 1, 0);
      vec++;
      if (bus.dp_valid !== 1'b0 || bus.dp_packet.pc === 32'hDEAD0) begin
        miss++;
        $display("FAIL squash_drop[%0d] valid=%b pc=%h want valid=0", i, bus.dp_valid,
                 bus.dp_packet.pc);
      end
      advance();
    end
  endtask

`ifdef IB_BYPASS_EN
  task automatic test_bypass();
    drive(1, 32'h40, 1, 1, 0);
    vec++;
    if (bus.dp_fire !== 1'b1 || bus.dp_valid !== 1'b1 || bus.dp_packet !== mk(32'h40) ||
        bus.ib_count !== 4'd0 || bus.ib_if_ready !== 1'b1) begin
      miss++;
      $display("FAIL bypass fire=%b valid=%b pc=%h cnt=%0d ready=%b want 1 1 40 0 1",
               bus.dp_fire, bus.dp_valid, bus.dp_packet.pc, bus.ib_count, bus.ib_if_ready);
    end
    advance();
    drive(0, 0, 1, 1, 0);
    vec++;
    if (bus.ib_count !== 4'd0 || bus.dp_valid !== 1'b0) begin
      miss++;
      $display("FAIL bypass_after cnt=%0d valid=%b want 0 0", bus.ib_count, bus.dp_valid);
    end
    advance();
  endtask
`endif

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h600 + 32'(4 * i), 0, 0, 0);
      advance();
    end
    cur_v = 0; cur_rob = 1; cur_rs = 1; cur_sq = 0;
    bus.if_valid = 0; bus.rob_dp_available = 1; bus.rs_dp_available = 1;
    #2;
    vec++;
    if (bus.dp_fire !== 1'b1 || bus.ib_count !== 4'd3) begin
      miss++;
      $display("FAIL pre_reset fire=%b cnt=%0d want 1 3", bus.dp_fire, bus.ib_count);
    end
    reset = 1'b1;
    #1;
    vec++;
    if (obs_st !== RstSt || bus.dp_packet !== '0) begin
      miss++;
      $display("FAIL async_reset st=%b pc=%h want st=%b pc=0", obs_st, bus.dp_packet.pc, RstSt);
    end
    exp_q.delete();
    m_head = 0;
    m_tail = 0;
    #2 reset = 1'b0;
    @(posedge clock);
    #1;
    drive(1, 32'h700, 0, 0, 0);
    advance();
    drive(0, 0, 0, 0, 0);
    vec++;
    if (obs_st !== exp_st || bus.dp_packet !== exp_pkt) begin
      miss++;
      $display("FAIL post_reset st=%b pc=%h want st=%b pc=%h", obs_st, bus.dp_packet.pc, exp_st,
               exp_pkt.pc);
    end
    advance();
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_full();
    test_simul_wrap();
    test_squash();
`ifdef IB_BYPASS_EN
    test_bypass();
`endif
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
